// File: rtl/nbyn_pkg.sv
// nbyn_pkg: flit layout and output FSM encoding shared by the nbyn network interfaces
package nbyn_pkg;
  localparam int DEF_X_SIZE = 1;
  localparam int DEF_Y_SIZE = 1;
  localparam int DEF_DATA_WIDTH = 256;
  localparam int X_LSB = 0;
  localparam int Y_LSB = X_LSB + DEF_X_SIZE;
  localparam int PAYLOAD_LSB = Y_LSB + DEF_Y_SIZE;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] payload;
    logic [DEF_Y_SIZE-1:0] dest_y;
    logic [DEF_X_SIZE-1:0] dest_x;
  } flit_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_e;
endpackage

// File: rtl/nbyn_sync_fifo.sv
// nbyn_sync_fifo: single-clock FIFO with head-of-queue read and occupancy count
module nbyn_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end
  always_ff @(posedge clk) if (wr_en) mem[wr_ptr] <= din;
endmodule

// File: rtl/nbyn_pe_inject.sv
// nbyn_pe_inject: core-to-switch PE injection port with FIFO, rate limiter and dest range check
// Define NBYN_PE_INJECT_STATS_EN to add sent/stall/drop counters.
module nbyn_pe_inject import nbyn_pkg::*; #(
  parameter int x_coord = 0,
  parameter int y_coord = 0,
  parameter int X = 2,
  parameter int Y = 2,
  parameter int data_width = DEF_DATA_WIDTH,
  parameter int x_size = DEF_X_SIZE,
  parameter int y_size = DEF_Y_SIZE,
  parameter int total_width = x_size + y_size + data_width,
  parameter int DEPTH = 4,
  parameter int INJ_GAP = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [x_size-1:0]      i_wr_dest_x,
  input  logic [y_size-1:0]      i_wr_dest_y,
  input  logic [data_width-1:0]  i_wr_data,
  output logic                   o_err_dest,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [total_width-1:0] o_data,
  output logic                   o_busy
`ifdef NBYN_PE_INJECT_STATS_EN
  ,
  output logic [31:0]            o_sent_cnt,
  output logic [31:0]            o_stall_cnt,
  output logic [15:0]            o_drop_cnt
`endif
);
  localparam int GW = $clog2(INJ_GAP + 2);
  state_e state;
  logic [GW-1:0] gap_cnt;
  logic [total_width-1:0] head;
  logic [$clog2(DEPTH):0] count;
  logic full, empty, live, acc, bad, push, pop, xfer;
  assign acc = i_wr_valid && o_wr_ready;
  assign bad = (int'(i_wr_dest_x) >= X) || (int'(i_wr_dest_y) >= Y);
  assign push = acc && !bad;
  assign xfer = o_valid && i_ready;
  assign pop = !empty && (state == IDLE || (state == SEND && xfer && INJ_GAP == 0) ||
                          (state == GAP && gap_cnt == GW'(1)));
  assign o_wr_ready = live && !full;
  assign o_busy = (count != '0) || o_valid || (state == GAP);
  nbyn_sync_fifo #(.WIDTH(total_width), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din({i_wr_data, i_wr_dest_y, i_wr_dest_x}),
    .dout(head), .count(count), .full(full), .empty(empty)
  );
  // live keeps the core from writing until the first cycle after reset is released
  always_ff @(posedge clk) begin
    live <= !rst;
    o_err_dest <= !rst && acc && bad;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      o_valid <= 1'b0;
      o_data <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          o_data <= head;
          o_valid <= 1'b1;
          state <= SEND;
        end
        SEND: if (xfer) begin
          if (INJ_GAP != 0) begin
            o_valid <= 1'b0;
            gap_cnt <= GW'(INJ_GAP);
            state <= GAP;
          end else if (!empty) o_data <= head;
          else begin
            o_valid <= 1'b0;
            state <= IDLE;
          end
        end
        GAP: if (gap_cnt == GW'(1)) begin
          if (!empty) begin
            o_data <= head;
            o_valid <= 1'b1;
            state <= SEND;
          end else state <= IDLE;
        end else gap_cnt <= gap_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef NBYN_PE_INJECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_sent_cnt <= '0;
      o_stall_cnt <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (xfer) o_sent_cnt <= o_sent_cnt + 1'b1;
      if (o_valid && !i_ready) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (acc && bad) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_nbyn_pe_inject.sv
// tb_nbyn_pe_inject: scoreboard bench for nbyn_pe_inject (INJ_GAP=0 and INJ_GAP=3 instances)
module tb_nbyn_pe_inject;
  localparam int XS = 2, YS = 2, DW = 16, TW = XS + YS + DW;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic wv0 = 0, wv3 = 0, rdy_in0 = 1, rdy_in3 = 1;
  logic [XS-1:0] dx = '0;
  logic [YS-1:0] dy = '0;
  logic [DW-1:0] wd = '0;
  logic wr_rdy0, wr_rdy3, err0, err3, ov0, ov3, busy0, busy3;
  logic [TW-1:0] od0, od3, e0, e3;
`ifdef NBYN_PE_INJECT_STATS_EN
  logic [31:0] sent0, stall0, sent3, stall3;
  logic [15:0] drop0, drop3;
`endif
  int vectors = 0, miscompares = 0, cyc = 0, stall_m = 0;
  logic [TW-1:0] q0[$], q3[$];
  int t3[$];

  nbyn_pe_inject #(.X(2), .Y(2), .data_width(DW), .x_size(XS), .y_size(YS), .DEPTH(4), .INJ_GAP(0)) u0 (
    .clk(clk), .rst(rst), .i_wr_valid(wv0), .o_wr_ready(wr_rdy0), .i_wr_dest_x(dx), .i_wr_dest_y(dy),
    .i_wr_data(wd), .o_err_dest(err0), .o_valid(ov0), .i_ready(rdy_in0), .o_data(od0), .o_busy(busy0)
`ifdef NBYN_PE_INJECT_STATS_EN
    , .o_sent_cnt(sent0), .o_stall_cnt(stall0), .o_drop_cnt(drop0)
`endif
  );
  nbyn_pe_inject #(.X(2), .Y(2), .data_width(DW), .x_size(XS), .y_size(YS), .DEPTH(4), .INJ_GAP(3)) u3 (
    .clk(clk), .rst(rst), .i_wr_valid(wv3), .o_wr_ready(wr_rdy3), .i_wr_dest_x(dx), .i_wr_dest_y(dy),
    .i_wr_data(wd), .o_err_dest(err3), .o_valid(ov3), .i_ready(rdy_in3), .o_data(od3), .o_busy(busy3)
`ifdef NBYN_PE_INJECT_STATS_EN
    , .o_sent_cnt(sent3), .o_stall_cnt(stall3), .o_drop_cnt(drop3)
`endif
  );

  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst) stall_m = 0; else if (ov0 && !rdy_in0) stall_m++;

  always @(negedge clk) if (ov0 && rdy_in0) begin
    vectors++;
    if (q0.size() == 0) begin
      miscompares++;
      $display("FAIL u0_unexpected_flit got=%h expected none", od0);
    end else begin
      e0 = q0.pop_front();
      if (od0 !== e0) begin miscompares++; $display("FAIL u0_flit got=%h expected=%h", od0, e0); end
    end
  end
  always @(negedge clk) if (ov3 && rdy_in3) begin
    vectors++;
    t3.push_back(cyc);
    if (q3.size() == 0) begin
      miscompares++;
      $display("FAIL u3_unexpected_flit got=%h expected none", od3);
    end else begin
      e3 = q3.pop_front();
      if (od3 !== e3) begin miscompares++; $display("FAIL u3_flit got=%h expected=%h", od3, e3); end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel3, input logic [XS-1:0] x, input logic [YS-1:0] y, input logic [DW-1:0] d);
    int n = 0;
    dx = x; dy = y; wd = d;
    if (sel3) wv3 = 1; else wv0 = 1;
    @(negedge clk);
    while (!(sel3 ? wr_rdy3 : wr_rdy0) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL wr_ready_timeout got=0 expected=1");
    end else if (x < 2 && y < 2) begin
      if (sel3) q3.push_back({d, y, x}); else q0.push_back({d, y, x});
    end
    @(posedge clk); #1;
    wv0 = 0; wv3 = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    tick(3);
    @(negedge clk);
    vectors += 5;
    if (ov0 !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b expected=0", ov0); end
    if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b expected=0", busy0); end
    if (od0 !== '0) begin miscompares++; $display("FAIL rst_data got=%h expected=0", od0); end
    if (wr_rdy0 !== 1'b0) begin miscompares++; $display("FAIL rst_wr_ready got=%b expected=0", wr_rdy0); end
    if (err0 !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b expected=0", err0); end
    @(posedge clk); #1 rst = 0;
    tick(2);
    @(negedge clk);
    vectors += 2;
    if (wr_rdy0 !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready0 got=%b expected=1", wr_rdy0); end
    if (wr_rdy3 !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready3 got=%b expected=1", wr_rdy3); end
    tick(1);
  endtask

  task automatic test_single;
    rdy_in0 = 1;
    wr(0, 2'd1, 2'd0, 16'h00A5);
    @(negedge clk);
    vectors += 2;
    if (ov0 !== 1'b0) begin miscompares++; $display("FAIL single_n1_valid got=%b expected=0", ov0); end
    if (busy0 !== 1'b1) begin miscompares++; $display("FAIL single_n1_busy got=%b expected=1", busy0); end
    @(negedge clk);
    vectors += 2;
    if (ov0 !== 1'b1) begin miscompares++; $display("FAIL single_n2_valid got=%b expected=1", ov0); end
    if (od0 !== {16'h00A5, 2'b00, 2'b01}) begin miscompares++; $display("FAIL single_data got=%h expected=%h", od0, {16'h00A5, 2'b00, 2'b01}); end
    @(negedge clk);
    vectors += 2;
    if (ov0 !== 1'b0) begin miscompares++; $display("FAIL single_n3_valid got=%b expected=0", ov0); end
    if (busy0 !== 1'b0) begin miscompares++; $display("FAIL single_busy_clear got=%b expected=0", busy0); end
    tick(1);
  endtask

  task automatic test_backpressure;
    rdy_in0 = 0;
    for (int i = 0; i < 5; i++) wr(0, 2'(i % 2), 2'((i / 2) % 2), 16'(16'h0100 + i));
    @(negedge clk);
    vectors += 2;
    if (wr_rdy0 !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got=%b expected=0", wr_rdy0); end
    if (ov0 !== 1'b1) begin miscompares++; $display("FAIL bp_valid got=%b expected=1", ov0); end
    repeat (20) @(negedge clk);
    vectors += 2;
    if (od0 !== {16'h0100, 2'b00, 2'b00}) begin miscompares++; $display("FAIL bp_hold_data got=%h expected=%h", od0, {16'h0100, 2'b00, 2'b00}); end
    if (ov0 !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid got=%b expected=1", ov0); end
    @(posedge clk); #1 rdy_in0 = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors += 2;
    if (busy0 !== 1'b0) begin miscompares++; $display("FAIL bp_drain_busy got=%b expected=0", busy0); end
    if (q0.size() != 0) begin miscompares++; $display("FAIL bp_drain_left got=%0d expected=0", q0.size()); end
    tick(1);
  endtask

  task automatic test_inj_gap;
    t3.delete();
    rdy_in3 = 1;
    for (int i = 0; i < 3; i++) wr(1, 2'd1, 2'd1, 16'(16'h00C0 + i));
    tick(25);
    vectors++;
    if (t3.size() != 3) begin miscompares++; $display("FAIL gap_count got=%0d expected=3", t3.size()); end
    else begin
      vectors += 2;
      if (t3[1] - t3[0] != 4) begin miscompares++; $display("FAIL gap_spacing1 got=%0d expected=4", t3[1] - t3[0]); end
      if (t3[2] - t3[1] != 4) begin miscompares++; $display("FAIL gap_spacing2 got=%0d expected=4", t3[2] - t3[1]); end
    end
  endtask

  task automatic test_range;
    logic [XS-1:0] bx[2] = '{2'd2, 2'd0};
    logic [YS-1:0] by[2] = '{2'd0, 2'd2};
    rdy_in0 = 1;
    wr(0, 2'd1, 2'd1, 16'h005A);
    @(negedge clk);
    vectors++;
    if (err0 !== 1'b0) begin miscompares++; $display("FAIL range_valid_err got=%b expected=0", err0); end
    tick(4);
    for (int i = 0; i < 2; i++) begin
      dx = bx[i]; dy = by[i]; wd = 16'hDEAD; wv0 = 1;
      @(posedge clk); #1 wv0 = 0;
      @(negedge clk);
      vectors += 2;
      if (err0 !== 1'b1) begin miscompares++; $display("FAIL range_err_pulse%0d got=%b expected=1", i, err0); end
      if (busy0 !== 1'b0) begin miscompares++; $display("FAIL range_busy%0d got=%b expected=0", i, busy0); end
      @(negedge clk);
      vectors += 2;
      if (err0 !== 1'b0) begin miscompares++; $display("FAIL range_err_end%0d got=%b expected=0", i, err0); end
      if (ov0 !== 1'b0) begin miscompares++; $display("FAIL range_emit%0d got=%b expected=0", i, ov0); end
      tick(2);
    end
  endtask

  task automatic test_reset_mid;
    rdy_in0 = 0;
    for (int i = 0; i < 4; i++) wr(0, 2'(i % 2), 2'd1, 16'(16'h0300 + i));
    @(negedge clk);
    vectors++;
    if (ov0 !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_valid got=%b expected=1", ov0); end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rdy_in0 = 1;
    q0.delete();
    @(negedge clk);
    vectors += 2;
    if (ov0 !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got=%b expected=0", ov0); end
    if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got=%b expected=0", busy0); end
    @(posedge clk); #1 rst = 0;
    tick(10);
    @(negedge clk);
    vectors++;
    if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rmid_stale got=%b expected=0", busy0); end
    tick(1);
  endtask

`ifdef NBYN_PE_INJECT_STATS_EN
  task automatic test_stats;
    int n = 0;
    rst = 1;
    tick(2);
    rst = 0;
    tick(2);
    rdy_in0 = 0;
    dx = 2'd3; dy = 2'd0; wd = 16'hBAD0; wv0 = 1;
    @(posedge clk); #1 wv0 = 0;
    for (int i = 0; i < 5; i++) wr(0, 2'd0, 2'd1, 16'(16'h0500 + i));
    while (stall_m < 7 && n < 100) begin @(posedge clk); n++; end
    #1 rdy_in0 = 1;
    tick(10);
    @(negedge clk);
    vectors += 3;
    if (sent0 !== 32'd5) begin miscompares++; $display("FAIL stats_sent got=%0d expected=5", sent0); end
    if (stall0 !== 32'd7) begin miscompares++; $display("FAIL stats_stall got=%0d expected=7", stall0); end
    if (drop0 !== 16'd1) begin miscompares++; $display("FAIL stats_drop got=%0d expected=1", drop0); end
    tick(1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_inj_gap;
    test_range;
    test_reset_mid;
`ifdef NBYN_PE_INJECT_STATS_EN
    test_stats;
`endif
    vectors++;
    if (q0.size() + q3.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d expected=0", q0.size() + q3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
